// File: rtl/matrix_elementwise_unit.sv
// Sequential element-wise matrix unit: add, subtract or scalar-multiply one element per clock,
// with wrap/saturate arithmetic, a sticky overflow flag and a start/busy/done handshake.
module matrix_elementwise_unit #(
    parameter int ELEM_W  = 8,
    parameter int MAX_DIM = 5,
    parameter int DIM_W   = 3
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [1:0]                              op,
    input  logic [DIM_W-1:0]                        m,
    input  logic [DIM_W-1:0]                        n,
    input  logic [ELEM_W-1:0]                       scalar,
    input  logic                                    saturate,
    input  logic [2*MAX_DIM*MAX_DIM*ELEM_W-1:0]     matrices_in,
    output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]       matrices_out,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    valid,
    output logic                                    error,
    output logic                                    overflow
);

    localparam int NUM   = MAX_DIM * MAX_DIM;
    localparam int HALF  = NUM * ELEM_W;
    localparam int IDX_W = $clog2(NUM + 1);
    localparam int PW    = 2 * ELEM_W;

    localparam logic [DIM_W-1:0]     MAX_DIM_V = DIM_W'(MAX_DIM);
    localparam logic signed [PW-1:0] MAX_V     = PW'((2 ** (ELEM_W - 1)) - 1);
    localparam logic signed [PW-1:0] MIN_V     = ~MAX_V;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_reg;
    logic [1:0]          op_reg;
    logic [DIM_W-1:0]    m_reg;
    logic [DIM_W-1:0]    n_reg;
    logic [DIM_W-1:0]    i_reg;
    logic [DIM_W-1:0]    j_reg;
    logic [ELEM_W-1:0]   scalar_reg;
    logic                sat_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                valid_reg;
    logic                error_reg;
    logic                overflow_reg;

    // Operands are captured whole at start so later input changes cannot disturb the run.
    logic [ELEM_W-1:0]   a_mem   [NUM];
    logic [ELEM_W-1:0]   b_mem   [NUM];
    logic [ELEM_W-1:0]   res_mem [NUM];

    logic                legal_req;
    logic                last_elem;
    logic [IDX_W-1:0]    idx;
    logic [ELEM_W-1:0]   a_el;
    logic [ELEM_W-1:0]   b_el;
    logic signed [PW-1:0] a_x;
    logic signed [PW-1:0] b_x;
    logic signed [PW-1:0] s_x;
    logic signed [PW-1:0] exact;
    logic [ELEM_W-1:0]   elem_res;
    logic                elem_ovf;

    assign legal_req = (m != '0) && (m <= MAX_DIM_V) &&
                       (n != '0) && (n <= MAX_DIM_V) &&
                       (op != 2'b11);

    assign last_elem = (i_reg == m_reg - DIM_W'(1)) && (j_reg == n_reg - DIM_W'(1));
    assign idx       = IDX_W'(i_reg) * IDX_W'(MAX_DIM) + IDX_W'(j_reg);
    assign a_el      = a_mem[idx];
    assign b_el      = b_mem[idx];

    // Operands are sign-extended to 2*ELEM_W so every result is exact before range checking.
    always_comb begin
        a_x   = {{ELEM_W{a_el[ELEM_W-1]}}, a_el};
        b_x   = {{ELEM_W{b_el[ELEM_W-1]}}, b_el};
        s_x   = {{ELEM_W{scalar_reg[ELEM_W-1]}}, scalar_reg};
        exact = '0;
        case (op_reg)
            OP_ADD:  exact = a_x + b_x;
            OP_SUB:  exact = a_x - b_x;
            OP_MUL:  exact = a_x * s_x;
            default: exact = '0;
        endcase

        elem_ovf = (exact > MAX_V) || (exact < MIN_V);
        elem_res = exact[ELEM_W-1:0];
        if (sat_reg && (exact > MAX_V)) begin
            elem_res = MAX_V[ELEM_W-1:0];
        end else if (sat_reg && (exact < MIN_V)) begin
            elem_res = MIN_V[ELEM_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            op_reg       <= '0;
            m_reg        <= '0;
            n_reg        <= '0;
            i_reg        <= '0;
            j_reg        <= '0;
            scalar_reg   <= '0;
            sat_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            valid_reg    <= 1'b0;
            error_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            for (int k = 0; k < NUM; k++) begin
                res_mem[k] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        op_reg       <= op;
                        m_reg        <= m;
                        n_reg        <= n;
                        scalar_reg   <= scalar;
                        sat_reg      <= saturate;
                        i_reg        <= '0;
                        j_reg        <= '0;
                        valid_reg    <= 1'b0;
                        overflow_reg <= 1'b0;
                        for (int k = 0; k < NUM; k++) begin
                            a_mem[k]   <= matrices_in[k*ELEM_W +: ELEM_W];
                            b_mem[k]   <= matrices_in[HALF + k*ELEM_W +: ELEM_W];
                            res_mem[k] <= '0;
                        end
                        if (legal_req) begin
                            state_reg <= RUN;
                            busy_reg  <= 1'b1;
                            error_reg <= 1'b0;
                        end else begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                            error_reg <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    res_mem[idx] <= elem_res;
                    overflow_reg <= overflow_reg | elem_ovf;
                    if (j_reg == n_reg - DIM_W'(1)) begin
                        j_reg <= '0;
                        i_reg <= i_reg + DIM_W'(1);
                    end else begin
                        j_reg <= j_reg + DIM_W'(1);
                    end
                    if (last_elem) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        valid_reg <= 1'b1;
                    end
                end

                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM; gi++) begin : g_out
            assign matrices_out[gi*ELEM_W +: ELEM_W] = res_mem[gi];
        end
    endgenerate

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign valid    = valid_reg;
    assign error    = error_reg;
    assign overflow = overflow_reg;

endmodule
